// File: rtl/ring_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_pkg
// Description : Shared types, fault codes and helpers for the ring monitor.
//               - state_t : HUNT / LOCKED / FAULT
//               - ERR_*   : fault cause codes reported on err_code
//               - rotl    : one-position left rotation of a ring vector
// Revision    : 1.0 - initial release
// ============================================================================
package ring_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_SKIP   = 2'b10;
    localparam logic [1:0] ERR_STALL  = 2'b11;

    // Rotates the low w bits of v left by one (MSB wraps to bit 0). Works on a
    // 32-bit container so a single function serves every ring width; bits at
    // and above w are returned as zero.
    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_onehot_enc.sv
`default_nettype none
// ============================================================================
// Module      : ring_onehot_enc
// Description : Combinational one-hot checker and binary encoder.
//   vec       in  WIDTH          : vector to inspect
//   is_onehot out 1              : exactly one bit of vec is set
//   idx       out $clog2(WIDTH)  : position of the set bit (OR of all set
//                                  positions when vec is not one-hot)
// Revision    : 1.0 - initial release
// ============================================================================
module ring_onehot_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         vec,
    output logic                     is_onehot,
    output logic [$clog2(WIDTH)-1:0] idx
);

    localparam int c_IDX_W = $clog2(WIDTH);

    // Non-zero with no second bit set: clearing the lowest set bit leaves 0.
    assign is_onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = idx | c_IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ring_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ring_monitor
// Description : Checker/decoder for a one-hot ring counter. Locks on bit 0,
//               follows legal hold/advance steps, counts revolutions and
//               latches the first sequence fault until clr_err.
//   clk       in  1              : clock, rising edge
//   rst       in  1              : synchronous active-high reset
//   ring_in   in  WIDTH          : one-hot ring vector
//   clr_err   in  1              : clears a fault and returns to HUNT
//   idx       out $clog2(WIDTH)  : binary phase index
//   valid     out 1              : LOCKED and idx trustworthy
//   rev_count out REV_W          : completed revolutions (wraps)
//   rev_pulse out 1              : one cycle per MSB->bit0 step
//   err       out 1              : sticky fault flag
//   err_code  out 2              : fault cause (see ring_pkg ERR_*)
// Revision    : 1.0 - initial release
// ============================================================================
module ring_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int REV_W     = 8,
    parameter int STALL_MAX = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     clr_err,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     valid,
    output logic [REV_W-1:0]         rev_count,
    output logic                     rev_pulse,
    output logic                     err,
    output logic [1:0]               err_code
);

    localparam int                   c_IDX_W      = $clog2(WIDTH);
    localparam int                   c_STALL_W    = $clog2(STALL_MAX + 1);
    localparam logic [WIDTH-1:0]     c_BIT0       = WIDTH'(1);
    // A hold sampled while the counter already shows STALL_MAX-1 holds is
    // the STALL_MAX-th consecutive one, which is the fault point.
    localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(STALL_MAX - 1);

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_prev, w_prev_nxt;
    logic [c_STALL_W-1:0] r_stall, w_stall_nxt;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic                 w_valid_nxt;
    logic [REV_W-1:0]     w_rev_nxt;
    logic                 w_pulse_nxt;
    logic                 w_err_nxt;
    logic [1:0]           w_code_nxt;

    logic                 w_onehot;
    logic [c_IDX_W-1:0]   w_enc_idx;
    logic                 w_is_adv;

    ring_onehot_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .vec       (ring_in),
        .is_onehot (w_onehot),
        .idx       (w_enc_idx)
    );

    // Legal advance: input equals the previous vector rotated by one.
    assign w_is_adv = (rotl(32'(r_prev), WIDTH) == 32'(ring_in));

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_stall_nxt = r_stall;
        w_idx_nxt   = idx;
        w_valid_nxt = 1'b0;
        w_rev_nxt   = rev_count;
        w_pulse_nxt = 1'b0;
        w_err_nxt   = err;
        w_code_nxt  = err_code;

        case (r_state)
            HUNT: begin
                if (ring_in == c_BIT0) begin
                    w_state_nxt = LOCKED;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_prev_nxt  = ring_in;
                    w_stall_nxt = '0;
                end
            end
            LOCKED: begin
                if (ring_in == r_prev) begin
                    if (r_stall == c_STALL_LAST) begin
                        w_state_nxt = FAULT;
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = ERR_STALL;
                    end else begin
                        w_stall_nxt = r_stall + c_STALL_W'(1);
                        w_valid_nxt = 1'b1;
                    end
                end else if (w_is_adv) begin
                    w_idx_nxt   = w_enc_idx;
                    w_prev_nxt  = ring_in;
                    w_stall_nxt = '0;
                    w_valid_nxt = 1'b1;
                    // A legal step out of the MSB can only land on bit 0.
                    if (r_prev[WIDTH-1]) begin
                        w_rev_nxt   = rev_count + REV_W'(1);
                        w_pulse_nxt = 1'b1;
                    end
                end else if (!w_onehot) begin
                    w_state_nxt = FAULT;
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = ERR_ONEHOT;
                end else begin
                    w_state_nxt = FAULT;
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = ERR_SKIP;
                end
            end
            FAULT: begin
                // Returning to HUNT only; locking needs a further edge.
                if (clr_err) begin
                    w_state_nxt = HUNT;
                    w_err_nxt   = 1'b0;
                    w_code_nxt  = ERR_NONE;
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= HUNT;
            r_prev    <= '0;
            r_stall   <= '0;
            idx       <= '0;
            valid     <= 1'b0;
            rev_count <= '0;
            rev_pulse <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_stall   <= w_stall_nxt;
            idx       <= w_idx_nxt;
            valid     <= w_valid_nxt;
            rev_count <= w_rev_nxt;
            rev_pulse <= w_pulse_nxt;
            err       <= w_err_nxt;
            err_code  <= w_code_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ring_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_monitor
// Description : Self-checking bench for ring_monitor. Two instances share the
//               stimulus: default parameters, and REV_W=2 to exercise the
//               revolution counter wrap. Expected values come from a
//               position/count reference model of the ring rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_monitor;

    localparam int W         = 4;
    localparam int STALL_MAX = 15;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       clr_err = 1'b0;
    logic [3:0] ring_in = 4'd0;

    logic [1:0] idx_a, idx_b;
    logic       valid_a, valid_b;
    logic [7:0] rev_a;
    logic [1:0] rev_b;
    logic       pulse_a, pulse_b;
    logic       err_a, err_b;
    logic [1:0] code_a, code_b;

    int checks   = 0;
    int failures = 0;

    // Reference model: ring position as an integer, hold run length, counts.
    bit m_locked = 1'b0;
    bit m_fault  = 1'b0;
    int m_pos    = 0;
    int m_holds  = 0;
    int m_rev    = 0;
    int m_code   = 0;
    bit m_pulse  = 1'b0;

    ring_monitor #(.WIDTH(W), .REV_W(8), .STALL_MAX(STALL_MAX)) u_dut_a (
        .clk(clk), .rst(rst), .ring_in(ring_in), .clr_err(clr_err),
        .idx(idx_a), .valid(valid_a), .rev_count(rev_a), .rev_pulse(pulse_a),
        .err(err_a), .err_code(code_a)
    );

    ring_monitor #(.WIDTH(W), .REV_W(2), .STALL_MAX(STALL_MAX)) u_dut_b (
        .clk(clk), .rst(rst), .ring_in(ring_in), .clr_err(clr_err),
        .idx(idx_b), .valid(valid_b), .rev_count(rev_b), .rev_pulse(pulse_b),
        .err(err_b), .err_code(code_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic go_fault(input int code);
        m_fault  = 1'b1;
        m_locked = 1'b0;
        m_code   = code;
    endtask

    task automatic model_step(input logic [3:0] s, input bit clr, input bit r);
        m_pulse = 1'b0;
        if (r) begin
            m_locked = 1'b0; m_fault = 1'b0; m_pos = 0;
            m_holds  = 0;    m_rev   = 0;    m_code = 0;
        end else if (m_fault) begin
            if (clr) begin
                m_fault = 1'b0;
                m_code  = 0;
            end
        end else if (!m_locked) begin
            if (s == 4'b0001) begin
                m_locked = 1'b1;
                m_pos    = 0;
                m_holds  = 0;
            end
        end else if (s == 4'(1 << m_pos)) begin
            m_holds++;
            if (m_holds >= STALL_MAX) go_fault(3);
        end else if ($countones(s) == 1 && s == 4'(1 << ((m_pos + 1) % W))) begin
            if (m_pos == W - 1) begin
                m_rev++;
                m_pulse = 1'b1;
            end
            m_pos   = (m_pos + 1) % W;
            m_holds = 0;
        end else if ($countones(s) != 1) begin
            go_fault(1);
        end else begin
            go_fault(2);
        end
    endtask

    task automatic check_all(input bit was_rst);
        chk("valid_a", 32'(valid_a), 32'(m_locked));
        chk("valid_b", 32'(valid_b), 32'(m_locked));
        chk("err_a", 32'(err_a), 32'(m_fault));
        chk("err_b", 32'(err_b), 32'(m_fault));
        chk("code_a", 32'(code_a), 32'(m_code));
        chk("code_b", 32'(code_b), 32'(m_code));
        chk("pulse_a", 32'(pulse_a), 32'(m_pulse));
        chk("pulse_b", 32'(pulse_b), 32'(m_pulse));
        chk("rev_a", 32'(rev_a), 32'(m_rev % 256));
        chk("rev_b", 32'(rev_b), 32'(m_rev % 4));
        if (m_locked || m_fault || was_rst) begin
            chk("idx_a", 32'(idx_a), 32'(m_pos));
            chk("idx_b", 32'(idx_b), 32'(m_pos));
        end
    endtask

    task automatic step(input logic [3:0] s, input bit clr, input bit r);
        ring_in = s;
        clr_err = clr;
        rst     = r;
        @(posedge clk);
        #1;
        model_step(s, clr, r);
        check_all(r);
    endtask

    task automatic lap();
        step(4'b0001, 0, 0);
        step(4'b0010, 0, 0);
        step(4'b0100, 0, 0);
        step(4'b1000, 0, 0);
    endtask

    initial begin
        logic [3:0] s;
        bit         clr;
        bit         r;

        // Reset values
        step(4'b0000, 0, 1);
        step(4'b0001, 0, 1);

        // HUNT ignores non-bit0 values, then three revolutions
        step(4'b0010, 0, 0);
        step(4'b0100, 0, 0);
        repeat (3) lap();
        step(4'b0001, 0, 0);
        chk("rev_after_3_laps", 32'(rev_a), 32'd3);

        // Not-one-hot fault, clear with 0001 present enters HUNT only
        step(4'b0010, 0, 0);
        step(4'b0110, 0, 0);
        step(4'b0001, 0, 0);
        step(4'b0001, 1, 0);
        chk("hunt_after_clr", 32'(valid_a), 32'd0);
        step(4'b0001, 0, 0);

        // Skip fault; later fault cause does not overwrite it
        step(4'b0010, 0, 0);
        step(4'b1000, 0, 0);
        step(4'b0101, 0, 0);
        chk("code_sticky", 32'(code_a), 32'd2);
        step(4'b0000, 1, 0);

        // 14 holds then advance: no fault; then 15 holds: stall fault
        step(4'b0001, 0, 0);
        step(4'b0010, 0, 0);
        step(4'b0100, 0, 0);
        repeat (14) step(4'b0100, 0, 0);
        step(4'b1000, 0, 0);
        repeat (14) step(4'b1000, 0, 0);
        chk("no_stall_at_14", 32'(err_a), 32'd0);
        step(4'b1000, 0, 0);
        chk("stall_at_15", 32'(code_a), 32'd3);
        step(4'b1000, 1, 0);

        // Five laps (REV_W=2 instance wraps), then reset mid-lap at idx 2
        step(4'b0001, 0, 0);
        repeat (5) begin
            step(4'b0010, 0, 0);
            step(4'b0100, 0, 0);
            step(4'b1000, 0, 0);
            step(4'b0001, 0, 0);
        end
        step(4'b0010, 0, 0);
        step(4'b0100, 0, 0);
        step(4'b0100, 0, 1);
        step(4'b0100, 0, 0);
        step(4'b1000, 0, 0);
        step(4'b0001, 0, 0);

        // Randomized traffic: mostly legal rotation with holds, corruptions,
        // clears in any state and occasional resets
        repeat (3000) begin
            r = ($urandom_range(0, 999) < 8);
            if (m_locked) begin
                case ($urandom_range(0, 99)) inside
                    [0:69]:  s = 4'(1 << ((m_pos + 1) % W));
                    [70:86]: s = 4'(1 << m_pos);
                    [87:93]: s = 4'(1 << $urandom_range(0, 3));
                    default: s = 4'($urandom_range(0, 15));
                endcase
            end else begin
                s = ($urandom_range(0, 1) == 1) ? 4'b0001 : 4'($urandom_range(0, 15));
            end
            clr = ($urandom_range(0, 99) < (m_fault ? 30 : 5));
            step(s, clr, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
